// File: rtl/digit_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed display: per-digit blank/show slots
// feeding a 2-to-4 enable decoder, with double-buffered display data.
module digit_scan_ctrl #(
    parameter int unsigned PRESCALE = 8,
    parameter int unsigned BLANK    = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RUN,
    input  logic        LOAD,
    input  logic [15:0] DIN,
    output logic        EN,
    output logic        I0,
    output logic        I1,
    output logic [3:0]  NIBBLE,
    output logic        FRAME,
    output logic        PENDING
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [15:0]       display_q, display_d;
    logic [15:0]       shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              en_q, en_d;
    logic              i0_q, i0_d;
    logic              i1_q, i1_d;
    logic [3:0]        nibble_q, nibble_d;
    logic              frame_q, frame_d;
    logic              slot_end;
    logic              commit;

    // Next-state, buffer and output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        slot_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                digit_d = 2'd0;
                if (RUN) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cnt_q == SLOT_LAST) begin
                    slot_end = 1'b1;
                    cnt_d    = '0;
                    if (RUN) begin
                        state_d = S_BLANK;
                        digit_d = digit_q + 2'd1;
                    end else begin
                        state_d = S_IDLE;
                        digit_d = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                digit_d = 2'd0;
            end
        endcase

        commit  = slot_end && (digit_q == 2'd3);
        frame_d = commit;

        // Newest data wins over an older pending shadow at the commit point
        if (state_q == S_IDLE) begin
            if (LOAD) begin
                display_d = DIN;
                shadow_d  = DIN;
                pending_d = 1'b0;
            end
        end else if (commit) begin
            if (LOAD) begin
                display_d = DIN;
                shadow_d  = DIN;
                pending_d = 1'b0;
            end else if (pending_q) begin
                display_d = shadow_q;
                pending_d = 1'b0;
            end
        end else if (LOAD) begin
            shadow_d  = DIN;
            pending_d = 1'b1;
        end

        en_d     = (state_d == S_SHOW);
        i0_d     = digit_d[1];
        i1_d     = digit_d[0];
        nibble_d = display_d[{digit_d, 2'b00} +: 4];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            digit_q   <= 2'd0;
            display_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            en_q      <= 1'b0;
            i0_q      <= 1'b0;
            i1_q      <= 1'b0;
            nibble_q  <= 4'h0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            i0_q      <= i0_d;
            i1_q      <= i1_d;
            nibble_q  <= nibble_d;
            frame_q   <= frame_d;
        end
    end

    assign EN      = en_q;
    assign I0      = i0_q;
    assign I1      = i1_q;
    assign NIBBLE  = nibble_q;
    assign FRAME   = frame_q;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: a table of per-cycle vectors covering
// four scan frames, plus hand-written reset sequences.
module tb_digit_scan_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        RUN;
    logic        LOAD;
    logic [15:0] DIN;
    logic        EN;
    logic        I0;
    logic        I1;
    logic [3:0]  NIBBLE;
    logic        FRAME;
    logic        PENDING;

    int total;
    int bad;

    typedef struct {
        logic        run;
        logic        load;
        logic [15:0] din;
        logic        en;
        logic [1:0]  dig;
        logic [3:0]  nib;
        logic        frame;
        logic        pend;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] frame_disp [4];

    digit_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .RUN     (RUN),
        .LOAD    (LOAD),
        .DIN     (DIN),
        .EN      (EN),
        .I0      (I0),
        .I1      (I1),
        .NIBBLE  (NIBBLE),
        .FRAME   (FRAME),
        .PENDING (PENDING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic en,
                           input logic [1:0] dig, input logic [3:0] nib,
                           input logic frame, input logic pend);
        chk({tag, "_en"},    idx, 16'(EN),      16'(en));
        chk({tag, "_i0"},    idx, 16'(I0),      16'(dig[1]));
        chk({tag, "_i1"},    idx, 16'(I1),      16'(dig[0]));
        chk({tag, "_nib"},   idx, 16'(NIBBLE),  16'(nib));
        chk({tag, "_frame"}, idx, 16'(FRAME),   16'(frame));
        chk({tag, "_pend"},  idx, 16'(PENDING), 16'(pend));
    endtask

    // Expected behaviour, slot by slot: s counts cycles after leaving IDLE
    function automatic void build_table();
        vec_t        v;
        logic [15:0] d;
        logic [1:0]  dg;
        // IDLE load: display written directly, digit 0 shows nibble 1
        v.run = 1'b0; v.load = 1'b1; v.din = 16'h4321;
        v.en = 1'b0; v.dig = 2'd0; v.nib = 4'h1; v.frame = 1'b0; v.pend = 1'b0;
        vecs.push_back(v);
        for (int s = 0; s < 124; s++) begin
            v.run  = (s < 116) ? 1'b1 : 1'b0;
            v.load = 1'b0;
            v.din  = 16'h0000;
            if (s == 10) begin v.load = 1'b1; v.din = 16'hABCD; end
            if (s == 64) begin v.load = 1'b1; v.din = 16'h1111; end
            if (s == 70) begin v.load = 1'b1; v.din = 16'h2222; end
            if (s == 80) begin v.load = 1'b1; v.din = 16'h3333; end
            if (s < 120) begin
                dg      = 2'((s / 8) % 4);
                d       = frame_disp[s / 32];
                v.en    = ((s % 8) >= 2) ? 1'b1 : 1'b0;
                v.dig   = dg;
                v.nib   = d[4 * int'(dg) +: 4];
                v.frame = ((s % 32) == 0 && s > 0) ? 1'b1 : 1'b0;
                v.pend  = ((s >= 10 && s < 32) || (s >= 70 && s < 96)) ? 1'b1 : 1'b0;
            end else begin
                v.en = 1'b0; v.dig = 2'd0; v.nib = 4'h3; v.frame = 1'b0; v.pend = 1'b0;
            end
            vecs.push_back(v);
        end
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        frame_disp[0] = 16'h4321;
        frame_disp[1] = 16'hABCD;
        frame_disp[2] = 16'h1111;
        frame_disp[3] = 16'h3333;
        build_table();

        RST_N = 1'b0;
        RUN   = 1'b0;
        LOAD  = 1'b0;
        DIN   = 16'h0000;
        tick();
        tick();
        chk_all("in_reset", 0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("idle", i, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        end

        // Four frames: scan, mid-frame load, load at commit, double load, RUN drop
        for (int i = 0; i < vecs.size(); i++) begin
            RUN  = vecs[i].run;
            LOAD = vecs[i].load;
            DIN  = vecs[i].din;
            tick();
            chk_all("vec", i, vecs[i].en, vecs[i].dig, vecs[i].nib,
                    vecs[i].frame, vecs[i].pend);
        end
        LOAD = 1'b0;
        DIN  = 16'h0000;

        // Reset during SHOW of digit 1 clears outputs without a clock edge
        RUN = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk_all("pre_rst", 0, 1'b1, 2'd1, 4'h3, 1'b0, 1'b0);
        RST_N = 1'b0;
        #1;
        chk_all("async_rst", 0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        #1;
        RST_N = 1'b1;
        tick();
        chk_all("restart", 0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        tick();
        chk_all("restart", 1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        tick();
        chk_all("restart", 2, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Time-multiplexed scan sequencer for the 4-digit display path. It sits directly upstream of the 2-to-4 enable decoder and drives its EN/I0/I1 inputs plus the 4-bit value for the currently selected digit. Each digit slot starts with a dead-time blank to avoid ghosting. Display data is double-buffered so a frame never tears.

Parameters:
PRESCALE, 8, clock cycles per digit slot (>= BLANK+1)
BLANK, 2, cycles at the start of each slot with EN forced low (>= 1)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
RUN  in  1  1 = scanning enabled; sampled each cycle
LOAD  in  1  1-cycle strobe: capture DIN as next display value
DIN  in  16  four nibbles; digit k = DIN[4k+3:4k]
EN  out  1  decoder enable
I0  out  1  digit index MSB (k[1])
I1  out  1  digit index LSB (k[0]); decoder asserts D{I0,I1}
NIBBLE  out  4  value of currently selected digit
FRAME  out  1  1-cycle pulse at end of each digit-3 slot
PENDING  out  1  shadow holds data not yet committed

Behaviour:
- Reset (RST_N low, async): state IDLE, slot counter 0, digit 0, EN=0, I0=I1=0, NIBBLE=0, FRAME=0, PENDING=0, display and shadow registers 0. All outputs are registered.
- States: IDLE, BLANK, SHOW. Slot counter cnt counts 0..PRESCALE-1 inside a slot.
- IDLE: EN=0, digit held at 0. If RUN=1 at an edge: next state BLANK, cnt=0, digit=0.
- BLANK: EN=0. I0/I1/NIBBLE already show the new digit. When cnt=BLANK-1, go to SHOW.
- SHOW: EN=1 for PRESCALE-BLANK cycles. At cnt=PRESCALE-1 the slot ends:
  - digit increments mod 4 (3 wraps to 0), cnt=0.
  - If RUN=1, go to BLANK. If RUN=0, go to IDLE with digit=0.
- RUN=0 during BLANK or mid-SHOW does not abort the slot; the slot completes, then the block goes to IDLE.
- Frame period is 4*PRESCALE cycles. EN duty per digit is (PRESCALE-BLANK)/PRESCALE.
- FRAME is high for the one cycle after the digit-3 slot ends, i.e. the first BLANK cycle of digit 0 or the first IDLE cycle.
- Double buffer:
  - LOAD=1 writes DIN into shadow and sets PENDING=1.
  - At each digit-3 slot end, if PENDING, shadow is copied to display and PENDING clears.
  - In IDLE, LOAD writes display and shadow directly; PENDING stays 0.
  - LOAD in the same cycle as a commit: DIN goes straight to display and PENDING=0 (newest data wins).
  - Multiple LOADs before a commit: the last one wins.
- NIBBLE is display[4k+3:4k] for the current digit k. It is updated on the same edge as I0/I1, so a committed value first appears on the digit-0 slot.
- Asserting reset mid-slot returns everything to the reset values immediately. Scanning resumes at digit 0 only after RST_N goes high and RUN=1.

Test Plan:
- Reset with RUN=0, then release -> EN=0, I0=I1=0, NIBBLE=0, FRAME=0 indefinitely.
- IDLE: LOAD DIN=16'h4321, then RUN=1 -> digit sequence 0,1,2,3,0; NIBBLE=1,2,3,4; each slot is EN=0 for 2 cycles then EN=1 for 6 cycles; FRAME pulses every 32 cycles.
- While scanning digit 1: LOAD DIN=16'hABCD -> PENDING=1; digits 2,3 still show 3,4; from the next digit-0 slot NIBBLE=D,C,B,A; PENDING=0.
- LOAD DIN=16'h1111 in the same cycle digit 3 ends -> the next digit 0 shows 1 and PENDING stays 0. Also, two LOADs (16'h2222, then 16'h3333) before a commit -> 3 is displayed.
- Drop RUN to 0 at cnt=3 of digit 2 -> digit 2 completes its 8 cycles, then IDLE with EN=0 and I0=I1=0; no FRAME pulse.
- Pull RST_N low during SHOW of digit 1 -> EN, I0, I1 and NIBBLE drop to 0 without waiting for a clock edge; after release with RUN=1, scanning restarts with a BLANK on digit 0 and the display register cleared to 0.
